// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : DLX instruction-fetch stage. Owns the program counter and
//                drives the word address of a synchronous instruction ROM
//                with 1-cycle read latency. Presents instruction, PC and
//                NPC to the IF/ID boundary. Handles ID stalls, EX redirects
//                and a terminal halt.
//  Ports       : clk, reset          - clock, async active-high reset
//                stall_i             - ID cannot accept, hold output
//                redirect_i/_pc_i    - taken branch/jump and its target
//                halt_i              - stop fetching until reset
//                rom_addr            - ROM word address (registered in ROM)
//                rom_rdata/_valid    - ROM data for last issued address
//                if_instr/pc/npc     - fetched instruction, its PC, PC+4
//                if_valid            - if_* carry a live instruction
//                halted              - fetch unit stopped
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  rom_rdata_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [PC_WIDTH-1:0]   if_npc,
    output logic                  if_valid,
    output logic                  halted
);

    localparam logic [1:0]          c_BOOT     = 2'd0;
    localparam logic [1:0]          c_RUN      = 2'd1;
    localparam logic [1:0]          c_HALTED   = 2'd2;
    localparam logic [PC_WIDTH-1:0] c_RESET_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] c_PC_STEP  = PC_WIDTH'(4);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [PC_WIDTH-1:0] r_req_pc;   // PC issued last cycle; its data is on rom_rdata now
    logic [PC_WIDTH-1:0] w_iss_pc;   // PC issued to the ROM this cycle
    logic                r_halted;
    logic                w_unused;

    // Issue-PC selection, highest priority first. A stall or missing ROM data
    // replays req_pc so the ROM re-reads it and the IF outputs stay stable.
    always_comb begin
        w_iss_pc = r_req_pc + c_PC_STEP;
        if (r_state == c_HALTED) begin
            w_iss_pc = r_req_pc;
        end else if (redirect_i) begin
            w_iss_pc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (r_state == c_BOOT) begin
            w_iss_pc = c_RESET_PC;
        end else if (stall_i || !rom_rdata_valid) begin
            w_iss_pc = r_req_pc;
        end
    end

    // Halt wins over redirect; HALTED is only left through reset.
    always_comb begin
        w_next_state = r_state;
        if (r_state != c_HALTED && halt_i) begin
            w_next_state = c_HALTED;
        end else if (r_state == c_BOOT) begin
            w_next_state = c_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_BOOT;
            r_req_pc <= c_RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == c_HALTED);
            // Freeze the PC on entry to HALTED so rom_addr stays constant.
            if (w_next_state != c_HALTED) begin
                r_req_pc <= w_iss_pc;
            end
        end
    end

    // PC bits above the ROM range alias onto the same words.
    assign rom_addr = w_iss_pc[ADDR_WIDTH+1:2];

    assign if_valid = (r_state == c_RUN) & rom_rdata_valid & ~redirect_i & ~halt_i;
    assign if_pc    = r_req_pc;
    assign if_npc   = r_req_pc + c_PC_STEP;
    assign if_instr = rom_rdata;
    assign halted   = r_halted;

    // Byte-offset bits and the aliased upper PC bits never reach the ROM.
    assign w_unused = ^{redirect_pc_i[1:0], w_iss_pc};

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. A second
//                instance with RESET_PC=0xFFC exercises ROM address aliasing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        rom_rdata_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        if_valid;
    logic        halted;

    logic        reset2;
    logic [9:0]  rom_addr2;
    logic [31:0] rom_rdata2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic [31:0] if_npc2;
    logic        if_valid2;
    logic        halted2;

    int n_err;
    int n_chk;

    fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .PC_WIDTH(32), .RESET_PC(0)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .halt_i          (halt_i),
        .rom_addr        (rom_addr),
        .rom_rdata       (rom_rdata),
        .rom_rdata_valid (rom_rdata_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_npc          (if_npc),
        .if_valid        (if_valid),
        .halted          (halted)
    );

    fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .PC_WIDTH(32), .RESET_PC(32'hFFC)) u_dut2 (
        .clk             (clk),
        .reset           (reset2),
        .stall_i         (1'b0),
        .redirect_i      (1'b0),
        .redirect_pc_i   (32'h0),
        .halt_i          (1'b0),
        .rom_addr        (rom_addr2),
        .rom_rdata       (rom_rdata2),
        .rom_rdata_valid (1'b1),
        .if_instr        (if_instr2),
        .if_pc           (if_pc2),
        .if_npc          (if_npc2),
        .if_valid        (if_valid2),
        .halted          (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: word content encodes its own address.
    always @(posedge clk) rom_rdata  <= 32'hC0DE_0000 | {22'd0, rom_addr};
    always @(posedge clk) rom_rdata2 <= 32'hBEEF_0000 | {22'd0, rom_addr2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        reset = 1'b1;
        reset2 = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        halt_i = 1'b0;
        rom_rdata_valid = 1'b1;
        tick();
        tick();

        // ---- 1: reset release, sequential fetch ----
        reset = 1'b0;
        #1;
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_addr", {22'd0, rom_addr}, 32'd0);
        chk("boot_pc", if_pc, 32'h0);
        chk("boot_npc", if_npc, 32'h4);
        chk("boot_halted", {31'd0, halted}, 32'd0);
        tick(); #1;
        chk("c1_valid", {31'd0, if_valid}, 32'd1);
        chk("c1_pc", if_pc, 32'h0);
        chk("c1_instr", if_instr, 32'hC0DE_0000);
        chk("c1_addr", {22'd0, rom_addr}, 32'd1);
        tick(); #1;
        chk("c2_pc", if_pc, 32'h4);
        chk("c2_npc", if_npc, 32'h8);
        chk("c2_addr", {22'd0, rom_addr}, 32'd2);
        tick(); #1;
        chk("c3_pc", if_pc, 32'h8);
        chk("c3_addr", {22'd0, rom_addr}, 32'd3);

        // ---- 2: stall for 3 cycles at if_pc=0x8 ----
        stall_i = 1'b1;
        #1;
        chk("st0_addr", {22'd0, rom_addr}, 32'd2);
        chk("st0_pc", if_pc, 32'h8);
        chk("st0_instr", if_instr, 32'hC0DE_0002);
        for (int i = 1; i < 3; i++) begin
            tick(); #1;
            chk("stn_pc", if_pc, 32'h8);
            chk("stn_instr", if_instr, 32'hC0DE_0002);
            chk("stn_addr", {22'd0, rom_addr}, 32'd2);
            chk("stn_valid", {31'd0, if_valid}, 32'd1);
        end
        tick();
        stall_i = 1'b0;
        #1;
        chk("st3_pc", if_pc, 32'h8);
        chk("st3_instr", if_instr, 32'hC0DE_0002);
        chk("st3_addr", {22'd0, rom_addr}, 32'd3);
        tick(); #1;
        chk("post_stall_pc", if_pc, 32'hC);
        tick(); #1;
        chk("c8_pc", if_pc, 32'h10);

        // ---- 3: redirect to 0x43 with stall also asserted ----
        redirect_i = 1'b1;
        redirect_pc_i = 32'h43;
        stall_i = 1'b1;
        #1;
        chk("rd_valid", {31'd0, if_valid}, 32'd0);
        chk("rd_addr", {22'd0, rom_addr}, 32'h10);
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("rd_tgt_pc", if_pc, 32'h40);
        chk("rd_tgt_valid", {31'd0, if_valid}, 32'd1);
        chk("rd_tgt_instr", if_instr, 32'hC0DE_0010);
        tick(); #1;
        chk("rd_next_pc", if_pc, 32'h44);

        // ---- 4: halt at if_pc=0x20, together with redirect ----
        redirect_i = 1'b1;
        redirect_pc_i = 32'h20;
        #1;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("h_pre_pc", if_pc, 32'h20);
        chk("h_pre_valid", {31'd0, if_valid}, 32'd1);
        halt_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        #1;
        chk("h_valid", {31'd0, if_valid}, 32'd0);
        chk("h_halted_pre", {31'd0, halted}, 32'd0);
        tick();
        halt_i = 1'b0;
        redirect_i = 1'b0;
        #1;
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_valid1", {31'd0, if_valid}, 32'd0);
        chk("h_addr1", {22'd0, rom_addr}, 32'd8);
        for (int i = 0; i < 4; i++) begin
            tick();
            redirect_i = i[0];
            stall_i = i[1];
            redirect_pc_i = 32'h200 + 32'(i * 4);
            #1;
            chk("h_hold_valid", {31'd0, if_valid}, 32'd0);
            chk("h_hold_addr", {22'd0, rom_addr}, 32'd8);
            chk("h_hold_pc", if_pc, 32'h20);
            chk("h_hold_halted", {31'd0, halted}, 32'd1);
        end
        redirect_i = 1'b0;
        stall_i = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("h_rst_halted", {31'd0, halted}, 32'd0);
        tick();

        // ---- 6: ROM data invalid for 2 cycles at 0x18, then reset ----
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #1;
        chk("v_pc", if_pc, 32'h18);
        rom_rdata_valid = 1'b0;
        #1;
        chk("v0_valid", {31'd0, if_valid}, 32'd0);
        chk("v0_addr", {22'd0, rom_addr}, 32'd6);
        tick(); #1;
        chk("v1_valid", {31'd0, if_valid}, 32'd0);
        chk("v1_addr", {22'd0, rom_addr}, 32'd6);
        chk("v1_pc", if_pc, 32'h18);
        tick();
        rom_rdata_valid = 1'b1;
        #1;
        chk("v2_valid", {31'd0, if_valid}, 32'd1);
        chk("v2_pc", if_pc, 32'h18);
        chk("v2_instr", if_instr, 32'hC0DE_0006);
        chk("v2_addr", {22'd0, rom_addr}, 32'd7);
        tick(); #1;
        chk("mr_pre_valid", {31'd0, if_valid}, 32'd1);
        chk("mr_pre_pc", if_pc, 32'h1C);
        reset = 1'b1;
        #1;
        chk("mr_valid", {31'd0, if_valid}, 32'd0);
        chk("mr_pc", if_pc, 32'h0);
        chk("mr_addr", {22'd0, rom_addr}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mr_boot_valid", {31'd0, if_valid}, 32'd0);
        tick(); #1;
        chk("mr_restart_pc", if_pc, 32'h0);
        chk("mr_restart_valid", {31'd0, if_valid}, 32'd1);

        // ---- 5: RESET_PC=0xFFC aliasing on the second instance ----
        reset2 = 1'b0;
        #1;
        chk("a_boot_addr", {22'd0, rom_addr2}, 32'd1023);
        chk("a_boot_valid", {31'd0, if_valid2}, 32'd0);
        tick(); #1;
        chk("a_pc0", if_pc2, 32'hFFC);
        chk("a_valid0", {31'd0, if_valid2}, 32'd1);
        chk("a_instr0", if_instr2, 32'hBEEF_03FF);
        chk("a_addr0", {22'd0, rom_addr2}, 32'd0);
        chk("a_npc0", if_npc2, 32'h1000);
        tick(); #1;
        chk("a_pc1", if_pc2, 32'h1000);
        chk("a_instr1", if_instr2, 32'hBEEF_0000);
        chk("a_addr1", {22'd0, rom_addr2}, 32'd1);
        chk("a_halted", {31'd0, halted2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
